// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and helpers for the round-robin mux arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, SWITCH)
//   ARB_MAX_N   : largest supported requester count
//   sel_width() : select-bus width for a given requester count (min 1 bit)
// ---------------------------------------------------------------------------
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SWITCH = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_N = 16;

    // Width of the mux select for n inputs; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter_if
// Bundle between the requesters/mux data sources and the arbiter.
//   req     : request vector, bit i = requester i
//   data    : mux data inputs, bit i belongs to requester i
//   gnt     : one-hot grant (arbiter output)
//   sel     : mux select, equal to the granted index
//   valid   : high while a grant is active
//   mux_out : data[sel] while valid, else 0
//   timeout : one-cycle pulse when a grant is forcibly revoked
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mux_rr_arbiter_if #(
    parameter int N = 16
) ();
    localparam int W = mux_arb_pkg::sel_width(N);

    logic [N-1:0] req;
    logic [N-1:0] data;
    logic [N-1:0] gnt;
    logic [W-1:0] sel;
    logic         valid;
    logic         mux_out;
    logic         timeout;

    modport master (
        output req,
        output data,
        input  gnt,
        input  sel,
        input  valid,
        input  mux_out,
        input  timeout
    );

    modport slave (
        input  req,
        input  data,
        output gnt,
        output sel,
        output valid,
        output mux_out,
        output timeout
    );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin winner search.
//   req    : request vector
//   ptr    : index of the last grant; the search starts at ptr+1
//   found  : at least one request bit is set
//   winner : first set request index at or after ptr+1, modulo N
// Method: rotate req so that index ptr+1 lands at bit 0, priority-encode the
// lowest set bit, then add the rotation back. N is a power of two, so the
// W-bit index arithmetic wraps modulo N for free.
// ---------------------------------------------------------------------------
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N = 16,
    localparam int W = sel_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] winner
);

    logic [W-1:0] start;
    logic [N-1:0] rot;
    logic [W-1:0] first;

    assign start = ptr + W'(1);

    // rot[k] is the request that sits k places after ptr in scan order.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = req[W'(gi) + start];
        end
    endgenerate

    // Lowest set bit of the rotated vector = nearest requester after ptr.
    always_comb begin
        first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                first = W'(i);
            end
        end
    end

    assign found  = |rot;
    assign winner = first + start;

endmodule

// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter that owns the select lines of an N:1 bit-select mux.
// A grant is held while the holder keeps its request high; consecutive
// grants are separated by one dead (SWITCH) cycle; priority rotates from
// the index after the last grant.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_rr_arbiter_if.slave (req, data in; gnt, sel, valid,
//           mux_out, timeout out)
// Parameters:
//   N        : requesters / mux inputs (2, 4, 8 or 16)
//   HOLD_MAX : GRANT cycles before a forced revoke (1..255), timeout build
// Build option:
//   MUX_ARB_TIMEOUT_EN : when defined, a hold counter revokes a grant after
//                        HOLD_MAX GRANT cycles and pulses timeout; when not
//                        defined, timeout is tied low and grants end only on
//                        request release.
// ---------------------------------------------------------------------------
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N        = 16,
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);

    localparam int W = sel_width(N);

    arb_state_t   state_reg, state_next;
    logic [W-1:0] ptr_reg,   ptr_next;
    logic [W-1:0] sel_reg,   sel_next;
    logic [N-1:0] gnt_reg,   gnt_next;
    logic         valid_reg, valid_next;

    logic         found;
    logic [W-1:0] winner;
    logic         holder_req;
    logic         hold_expired;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_reg),
        .found  (found),
        .winner (winner)
    );

    // sel_reg always names the current (or most recent) holder.
    assign holder_req = bus.req[sel_reg];

    // ------------------------------------------------------------------
    // Optional hold-time limit
    // ------------------------------------------------------------------
`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt_reg, hold_cnt_next;
    logic       timeout_reg,  timeout_next;

    // Counter reads 0 in the first GRANT cycle and k in the (k+1)-th, so the
    // grant lasts exactly HOLD_MAX cycles when it expires at HOLD_LAST.
    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (state_reg == GRANT) begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
        end
        if ((state_next == GRANT) && (state_reg != GRANT)) begin
            hold_cnt_next = 8'd0;
        end
    end

    assign hold_expired = (hold_cnt_reg == HOLD_LAST);

    // Pulse only for a real revoke, not for a voluntary release.
    assign timeout_next = (state_reg == GRANT) && holder_req && hold_expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= 8'd0;
            timeout_reg  <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign bus.timeout = timeout_reg;
`else
    logic unused_cfg;

    assign unused_cfg   = ^(8'(HOLD_MAX));
    assign hold_expired = 1'b0;
    assign bus.timeout  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= W'(N - 1);
            sel_reg   <= '0;
            gnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
            gnt_reg   <= gnt_next;
            valid_reg <= valid_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    // A revoked holder is still in ptr_reg, so the scan from ptr+1 reaches
    // it last and it only wins again when nobody else is asking.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE, SWITCH: begin
                if (found) begin
                    state_next = GRANT;
                    ptr_next   = winner;
                    sel_next   = winner;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                if (!holder_req || hold_expired) begin
                    state_next = SWITCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs are loaded from the next state so gnt/valid are
    // visible in the first GRANT cycle rather than one cycle later.
    assign valid_next = (state_next == GRANT);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_gnt
            assign gnt_next[gi] = (state_next == GRANT) && (sel_next == W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs and mux datapath
    // ------------------------------------------------------------------
    assign bus.gnt     = gnt_reg;
    assign bus.sel     = sel_reg;
    assign bus.valid   = valid_reg;
    assign bus.mux_out = valid_reg ? bus.data[sel_reg] : 1'b0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Self-checking bench for mux_rr_arbiter (N = 16). A behavioural model
// tracks owner / last-granted index from the round-robin rules and is
// compared with the DUT on every falling clock edge; directed scenarios add
// literal expectations. Inputs change 2 time units after each rising edge.
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

    localparam int N  = 16;
    localparam int HM = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.N(N)) bus ();

    mux_rr_arbiter #(
        .N        (N),
        .HOLD_MAX (HM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_owner;   // granted requester, -1 when nobody holds the mux
    int m_last;    // most recently granted index
    int m_sel;     // expected sel (holds across gaps)
    int m_held;    // completed GRANT cycles of the current holder
    bit m_to;      // expected timeout pulse

    // First requester strictly after 'last' in circular order, -1 if none.
    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_last  <= N - 1;
            m_sel   <= 0;
            m_held  <= 0;
            m_to    <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (m_owner >= 0) begin
                if (!bus.req[m_owner]) begin
                    m_owner <= -1;
                end else if (TO_EN && (m_held + 1 == HM)) begin
                    m_owner <= -1;
                    m_to    <= 1'b1;
                end else begin
                    m_held <= m_held + 1;
                end
            end else if (pick(bus.req, m_last) >= 0) begin
                m_owner <= pick(bus.req, m_last);
                m_last  <= pick(bus.req, m_last);
                m_sel   <= pick(bus.req, m_last);
                m_held  <= 0;
            end
        end
    end

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_gnt",     32'(bus.gnt),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("model_valid",   32'(bus.valid),   32'(m_owner >= 0));
            chk("model_sel",     32'(bus.sel),     32'(m_sel));
            chk("model_mux_out", 32'(bus.mux_out), (m_owner >= 0) ? 32'(bus.data[m_owner]) : 32'd0);
            chk("model_timeout", 32'(bus.timeout), 32'(m_to));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.data = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_gnt",     32'(bus.gnt),     32'd0);
        chk("rst_valid",   32'(bus.valid),   32'd0);
        chk("rst_sel",     32'(bus.sel),     32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
    endtask

    int exp_order [5] = '{0, 5, 10, 15, 0};

    initial begin
        logic [N-1:0] rq;
        int s;

        // Reset priority: requester 0 beats 5.
        do_reset();
        bus.req  = 16'h0021;
        bus.data = 16'h0001;
        step();
        chk("prio_gnt",   32'(bus.gnt),     32'h0001);
        chk("prio_sel",   32'(bus.sel),     32'd0);
        chk("prio_valid", 32'(bus.valid),   32'd1);
        chk("prio_mux",   32'(bus.mux_out), 32'd1);

        // Rotation with 3-cycle holds and one dead cycle between grants.
        do_reset();
        rq      = 16'h8421;
        bus.req = rq;
        for (int g = 0; g < 5; g++) begin
            bus.data = 16'($urandom);
            step();
            chk("rot_valid", 32'(bus.valid), 32'd1);
            chk("rot_sel",   32'(bus.sel),   32'(exp_order[g]));
            s = exp_order[g];
            step();
            step();
            rq[s]   = 1'b0;
            bus.req = rq;
            step();
            chk("rot_gap", 32'(bus.valid), 32'd0);
            rq[s]   = 1'b1;
            bus.req = rq;
        end

        // Wrap-around from ptr = 15.
        do_reset();
        bus.req = 16'h8000;
        step();
        chk("wrap_sel15", 32'(bus.sel), 32'd15);
        bus.req = 16'h0003;
        step();
        chk("wrap_gap", 32'(bus.valid), 32'd0);
        step();
        chk("wrap_gnt0", 32'(bus.gnt), 32'h0001);
        bus.req = 16'h0002;
        step();
        chk("wrap_gap2", 32'(bus.valid), 32'd0);
        step();
        chk("wrap_gnt1", 32'(bus.gnt), 32'h0002);

`ifndef MUX_ARB_TIMEOUT_EN
        // Sole requester keeps the grant indefinitely.
        do_reset();
        bus.req = 16'h0010;
        for (int c = 0; c < 40; c++) begin
            step();
            chk("sole_gnt",     32'(bus.gnt),     32'h0010);
            chk("sole_timeout", 32'(bus.timeout), 32'd0);
        end
`else
        // Forced revoke after HM grant cycles.
        do_reset();
        bus.req = 16'h0012;
        for (int c = 0; c < HM; c++) begin
            step();
            chk("revoke_hold", 32'(bus.gnt), 32'h0002);
        end
        step();
        chk("revoke_valid",   32'(bus.valid),   32'd0);
        chk("revoke_timeout", 32'(bus.timeout), 32'd1);
        step();
        chk("revoke_next", 32'(bus.gnt), 32'h0010);
`endif

        // Reset mid-grant drops outputs immediately.
        do_reset();
        bus.req  = 16'h0080;
        bus.data = 16'hFFFF;
        step();
        chk("mid_gnt7", 32'(bus.gnt), 32'h0080);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",   32'(bus.gnt),     32'd0);
        chk("mid_rst_valid", 32'(bus.valid),   32'd0);
        chk("mid_rst_mux",   32'(bus.mux_out), 32'd0);
        bus.req = 16'h0081;
        step();
        rst_n = 1'b1;
        step();
        chk("mid_after_gnt", 32'(bus.gnt), 32'h0001);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rq = 16'($urandom & $urandom & $urandom);
            if (m_owner >= 0 && $urandom_range(7) != 0) begin
                rq[m_owner] = 1'b1;
            end
            bus.req  = rq;
            bus.data = 16'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
